servo_pwm_multi: RTL

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pkg.sv | 14 +
 rtl/servo_channel.sv | 79 +++++++
 rtl/servo_pwm_multi.sv | 81 ++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared timing defaults and the channel-select width helper for the servo PWM block.
package servo_pkg;

   localparam int DEF_CNT_W         = 32;
   localparam int DEF_PERIOD_CYCLES = 1000000;
   localparam int DEF_MIN_PULSE     = 50000;
   localparam int DEF_MAX_PULSE     = 100000;
   localparam int DEF_RAMP_STEP     = 500;

   function automatic int chanWidth(input int nCh);
      return (nCh > 1) ? $clog2(nCh) : 1;
   endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: clamped target register, frame-synchronous active width and registered PWM.
// Optional ramping of the active width is enabled with SERVO_RAMP_EN.
module servo_channel
   import servo_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MIN_PULSE   = DEF_MIN_PULSE,
   parameter int MAX_PULSE   = DEF_MAX_PULSE,
`ifdef SERVO_RAMP_EN
   parameter int RAMP_STEP   = DEF_RAMP_STEP,
`endif
   parameter int RESET_WIDTH = 0
) (
   input  logic             i_clock,
   input  logic             i_reset_low,
   input  logic             i_wr_en,
   input  logic [CNT_W-1:0] i_wr_width,
   input  logic             i_update,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_pwm,
   output logic             o_at_target
);

   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_active;
   logic             r_pwm;
   logic [CNT_W-1:0] w_clamped;
   logic [CNT_W-1:0] w_next_active;

   // Zero means "off" and must survive the lower clamp untouched.
   always_comb begin
      w_clamped = i_wr_width;
      if (i_wr_width == '0) begin
         w_clamped = '0;
      end else if (i_wr_width < CNT_W'(MIN_PULSE)) begin
         w_clamped = CNT_W'(MIN_PULSE);
      end else if (i_wr_width > CNT_W'(MAX_PULSE)) begin
         w_clamped = CNT_W'(MAX_PULSE);
      end
   end

`ifdef SERVO_RAMP_EN
   // Switching a channel on or off is immediate; only live-to-live changes are rate limited.
   always_comb begin
      w_next_active = r_target;
      if (r_target != '0 && r_active != '0) begin
         if (r_target > r_active) begin
            if (r_target - r_active > CNT_W'(RAMP_STEP)) begin
               w_next_active = r_active + CNT_W'(RAMP_STEP);
            end
         end else if (r_active - r_target > CNT_W'(RAMP_STEP)) begin
            w_next_active = r_active - CNT_W'(RAMP_STEP);
         end
      end
   end
`else
   assign w_next_active = r_target;
`endif

   always_ff @(posedge i_clock or negedge i_reset_low) begin
      if (!i_reset_low) begin
         r_target <= CNT_W'(RESET_WIDTH);
         r_active <= CNT_W'(RESET_WIDTH);
         r_pwm    <= 1'b0;
      end else begin
         if (i_wr_en) begin
            r_target <= w_clamped;
         end
         if (i_update) begin
            r_active <= w_next_active;
         end
         r_pwm <= (i_count < r_active);
      end
   end

   assign o_pwm       = r_pwm;
   assign o_at_target = (r_active == r_target);

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter, command handshake and channel decode.
// Define SERVO_RAMP_EN to rate-limit active width changes by RAMP_STEP per frame.
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
   parameter int MIN_PULSE     = DEF_MIN_PULSE,
   parameter int MAX_PULSE     = DEF_MAX_PULSE,
   parameter int RESET_WIDTH   = 0,
   parameter int RAMP_STEP     = DEF_RAMP_STEP,
   localparam int CH_W         = chanWidth(N_CH)
) (
   input  logic             clock_clk,
   input  logic             reset_low,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CH_W-1:0]  cmd_chan,
   input  logic [CNT_W-1:0] cmd_width,
   output logic             cmd_err,
   output logic             frame_start,
   output logic [N_CH-1:0]  pwm_out,
   output logic [N_CH-1:0]  at_target
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] r_count;
   logic             r_cmd_err;
   logic             r_frame_start;
   logic             w_last;
   logic             w_accept;
   logic             w_bad_chan;
   logic [N_CH-1:0]  w_wr_en;

   // Commands are held off on the update cycle so a write never races the target-to-active copy.
   assign w_last     = (r_count == LAST_COUNT);
   assign cmd_ready  = reset_low && !w_last;
   assign w_accept   = cmd_valid && cmd_ready;
   assign w_bad_chan = (32'(cmd_chan) >= N_CH);

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         r_count       <= '0;
         r_cmd_err     <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_count       <= w_last ? '0 : r_count + CNT_W'(1);
         r_cmd_err     <= w_accept && w_bad_chan;
         r_frame_start <= (r_count == '0);
      end
   end

   assign cmd_err     = r_cmd_err;
   assign frame_start = r_frame_start;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_wr_en[i] = w_accept && !w_bad_chan && (cmd_chan == CH_W'(i));

      servo_channel #(
         .CNT_W       (CNT_W),
         .MIN_PULSE   (MIN_PULSE),
         .MAX_PULSE   (MAX_PULSE),
`ifdef SERVO_RAMP_EN
         .RAMP_STEP   (RAMP_STEP),
`endif
         .RESET_WIDTH (RESET_WIDTH)
      ) u_channel (
         .i_clock     (clock_clk),
         .i_reset_low (reset_low),
         .i_wr_en     (w_wr_en[i]),
         .i_wr_width  (cmd_width),
         .i_update    (w_last),
         .i_count     (r_count),
         .o_pwm       (pwm_out[i]),
         .o_at_target (at_target[i])
      );
   end

endmodule
